alu_issue_ctrl: RTL
===================

// Module: alu_issue_ctrl
// PURPOSE
//  Initiator side of the vector ALU interface: accepts one ALU operation (opcode, function, WW, operands, dest tag)
//  over a valid/ready handshake, registers and holds the ALU inputs for the op's latency, then captures ALU_out.
//  It returns the captured result, with tag and error flag, over a second valid/ready handshake.
//  Sits between register-read/decode and writeback; the ALU itself is purely combinational.
// PARAMETERS
//  DATA_W     64  operand/result width, big-endian bit order [0:DATA_W-1]
//  MULTI_LAT  4   cycles ALU inputs are held before capture for multi-cycle functions (>=1)
//  TAG_W      5   destination register tag width
// PORTS
//  clk          in   1       system clock, all state on rising edge
//  reset        in   1       synchronous, active-high
//  in_valid     in   1       upstream operation valid
//  in_ready     out  1       block can accept an operation this cycle
//  in_opcode    in   6       primary opcode; only 6'b101010 (vector ALU) is legal
//  in_func      in   6       R_ins function code
//  in_ww        in   2       lane width: 00=8b, 01=16b, 10=32b, 11=64b
//  in_tag       in   TAG_W   destination tag, returned unchanged
//  in_ra        in   DATA_W  rA operand
//  in_rb        in   DATA_W  rB operand
//  alu_ra       out  DATA_W  to ALU rA_64bit_val
//  alu_rb       out  DATA_W  to ALU rB_64bit_val
//  alu_func     out  6       to ALU R_ins
//  alu_opcode   out  6       to ALU Op_code
//  alu_ww       out  2       to ALU WW
//  alu_out      in   DATA_W  from ALU ALU_out
//  out_valid    out  1       result valid
//  out_ready    in   1       downstream accepts result
//  out_data     out  DATA_W  captured result
//  out_tag      out  TAG_W   tag of the result
//  out_err      out  1       1 = illegal opcode/function; out_data is 0
// BEHAVIOUR
//  - Reset: state IDLE; out_valid, out_err, out_data, out_tag, all alu_* outputs = 0; in_ready = 0 while reset is high.
//  - States: IDLE, EXEC, DONE. in_ready = (IDLE) | (DONE & out_ready); never asserted in EXEC.
//  - Accept = in_valid & in_ready at edge E0: alu_* <= inputs, tag latched, cnt <= lat-1, go EXEC.
//    Exception: an illegal op goes straight to DONE (out_err=1, out_data=0) and alu_* are NOT updated.
//  - Legal: opcode==6'b101010 and func in 6'b000001..6'b010010; anything else is illegal.
//  - lat = MULTI_LAT for func 001000 VMULEU, 001001 VMULOU, 001110 VDIV, 001111 VMOD, 010010 VSQRT; else 1.
//  - EXEC: alu_* held stable. If cnt==0, capture out_data <= alu_out at that edge, out_err <= 0, go DONE; else cnt--.
//    Capture therefore occurs at edge E0+lat; out_valid is high from the cycle after that edge.
//  - DONE: out_valid=1; out_data/out_tag/out_err held stable until out_valid & out_ready.
//    On that handshake, if in_valid: accept the new op at the same edge (back-to-back, no bubble). Else go IDLE.
//  - alu_* hold their last values in IDLE/DONE: no toggling without a new accepted op.
//  - Reset mid-EXEC or mid-DONE: the operation is dropped, no out_valid is produced, all outputs return to reset values.
//  - The block does no arithmetic; lane/width semantics belong to the ALU. out_data is alu_out captured bit-exact.
// TESTING
//  1. VAND func 000001, ra=15, rb=14, WW=10, out_ready=1 -> out_valid 2nd cycle after accept, out_data=14, out_err=0.
//  2. VADD func 000110, WW=00, ra=64'hFFFFFFFF_FFFFFFFF, rb=64'h00000000_11111111 -> out_data=64'hFFFFFFFF_10101010.
//  3. VMOD func 001111, WW=11, ra=102, rb=10 -> alu_* stable 4 cycles, out_valid at accept+5 cycles, out_data=2.
//  4. Back-pressure: out_ready=0 for 5 cycles after result, 2nd op pending -> out_* stable, in_ready=0;
//     out_ready=1 -> both handshakes at one edge, 2nd result follows with no bubble.
//  5. Illegal: in_opcode=6'b000000 or in_func=6'b111111 -> out_valid next cycle, out_err=1, out_data=0, alu_* unchanged.
//  6. Reset asserted during cycle 2 of a VDIV -> out_valid never rises, all outputs 0, in_ready=1 the cycle after release.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one op to the combinational vector ALU, holds the
// operands for the op's latency, then returns the captured result.
module alu_issue_ctrl #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned MULTI_LAT = 4,
  parameter int unsigned TAG_W     = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_opcode,
  input  logic [5:0]        in_func,
  input  logic [1:0]        in_ww,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic [0:DATA_W-1] in_ra,
  input  logic [0:DATA_W-1] in_rb,
  output logic [0:DATA_W-1] alu_ra,
  output logic [0:DATA_W-1] alu_rb,
  output logic [5:0]        alu_func,
  output logic [5:0]        alu_opcode,
  output logic [1:0]        alu_ww,
  input  logic [0:DATA_W-1] alu_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [0:DATA_W-1] out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_err
);

  localparam int unsigned CNT_W    = ($clog2(MULTI_LAT) < 1) ? 1 : $clog2(MULTI_LAT);
  localparam logic [5:0]  OP_VALU  = 6'b101010;
  localparam logic [5:0]  FUNC_MIN = 6'b000001;
  localparam logic [5:0]  FUNC_MAX = 6'b010010;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               accept;
  logic               legal;
  logic               long_lat;
  logic [CNT_W-1:0]   lat_m1;
  logic               capture;

  // Decode legality and latency of the offered op
  always_comb begin
    legal    = (in_opcode == OP_VALU) && (in_func >= FUNC_MIN) && (in_func <= FUNC_MAX);
    long_lat = (in_func == 6'b001000) || (in_func == 6'b001001) || (in_func == 6'b001110) ||
               (in_func == 6'b001111) || (in_func == 6'b010010);
    lat_m1   = long_lat ? CNT_W'(MULTI_LAT - 1) : '0;
  end

  // Accept when idle, or when the held result is being taken this cycle
  assign in_ready = !reset && ((state_q == IDLE) || ((state_q == DONE) && out_ready));
  assign accept   = in_valid && in_ready;

  // State and latency counter register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; illegal ops skip EXEC and report an error directly
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = legal ? EXEC : DONE;
          cnt_d   = lat_m1;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          capture = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          if (accept) begin
            state_d = legal ? EXEC : DONE;
            cnt_d   = lat_m1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // ALU operand hold registers and result/tag capture
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_ra     <= '0;
      alu_rb     <= '0;
      alu_func   <= '0;
      alu_opcode <= '0;
      alu_ww     <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_tag    <= '0;
      out_err    <= 1'b0;
    end else begin
      out_valid <= (state_d == DONE);
      if (accept) begin
        out_tag <= in_tag;
        if (legal) begin
          alu_ra     <= in_ra;
          alu_rb     <= in_rb;
          alu_func   <= in_func;
          alu_opcode <= in_opcode;
          alu_ww     <= in_ww;
        end else begin
          out_err  <= 1'b1;
          out_data <= '0;
        end
      end
      if (capture) begin
        out_data <= alu_out;
        out_err  <= 1'b0;
      end
    end
  end

endmodule
